data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored; the value SHALL be a power of two, minimum 4.
REQ-002 Parameter LATENCY, default 2, number of WAIT cycles between request acceptance and response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a data-memory request this cycle.
REQ-006 MemWrite  input  1  1 = store, 0 = load; sampled with req_valid.
REQ-007 Addr  input  32  byte address (core ALUResult_M).
REQ-008 WriteData  input  32  store data (core WriteData_M).
REQ-009 ReadData  output  32  load data; valid only while resp_valid=1.
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 busy  output  1  stall request to core hazard logic; high while a request is outstanding.
REQ-012 misalign_err  output  1  error flag; valid only while resp_valid=1.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 In IDLE with req_valid=1, the block SHALL latch MemWrite, Addr and WriteData at the edge, load the wait counter with LATENCY-1, and enter WAIT.
REQ-015 In IDLE with req_valid=0, the block SHALL remain in IDLE.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at counter=0 the next edge SHALL enter RESP.
REQ-017 RESP SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 resp_valid SHALL be high in the cycle LATENCY+1 after the accepting edge.
REQ-019 The block SHALL ignore req_valid in WAIT and RESP; no second request is queued.
REQ-020 busy SHALL be 1 in WAIT and 0 in IDLE and RESP.
REQ-021 resp_valid SHALL be 1 only in RESP.
REQ-022 Word index SHALL be latched Addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 An aligned store (Addr[1:0]=0) SHALL write the latched data into the array on the edge entering RESP.
REQ-024 An aligned load SHALL register the array word on the edge entering RESP and drive it on ReadData during RESP.
REQ-025 A load that follows a store to the same word SHALL return the stored value.
REQ-026 Misaligned access (Addr[1:0]≠0) SHALL perform no write, drive ReadData=0 and misalign_err=1 during RESP, and keep normal timing.
REQ-027 Outside RESP, ReadData SHALL be 0 and misalign_err SHALL be 0.
REQ-028 On a store response, ReadData SHALL be 0.

Reset
REQ-029 Reset SHALL set state to IDLE, the counter to 0, and busy, resp_valid, misalign_err and ReadData to 0.
REQ-030 Reset SHALL clear latched request registers to 0.
REQ-031 Reset during WAIT SHALL abort the request, with no array write and no resp_valid pulse.
REQ-032 Array contents SHALL NOT be cleared by reset; simulation initializes them to 0.
REQ-033 reset SHALL take priority over req_valid in the same cycle.

Structure
REQ-034 Package mem_resp_pkg SHALL hold the FSM state enum and the constants DEF_DEPTH_WORDS=64 and DEF_LATENCY=2.
REQ-035 Storage SHALL be a sub-module mem_word_array: synchronous write, registered read, DEPTH_WORDS x 32.
REQ-036 The FSM, counter and error logic SHALL reside in data_mem_responder.

Verification
REQ-037 Reset, idle 5 cycles -> busy=0, resp_valid=0, ReadData=0 throughout.
REQ-038 LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each resp_valid exactly 3 cycles after acceptance; load ReadData=0xDEADBEEF; busy high for 2 cycles per request.
REQ-039 Load 0x0000_0013 -> resp_valid with misalign_err=1, ReadData=0; word 4 unchanged.
REQ-040 DEPTH_WORDS=64: store 0x12345678 to 0x100, load 0x0 -> ReadData=0x12345678 (wrap).
REQ-041 req_valid held high continuously for 3 requests -> one response per 4 cycles (LATENCY=2); requests during WAIT/RESP are dropped.
REQ-042 Store to 0x20 accepted, reset asserted during WAIT -> no resp_valid; later load 0x20 returns the prior contents (0).

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state encoding and the default geometry/timing.
package mem_resp_pkg;

    localparam int DEF_DEPTH_WORDS = 64;
    localparam int DEF_LATENCY     = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, registered read.
// Contents are never cleared by reset.
module mem_word_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for a pipelined RISC-V core.
// One outstanding request; misaligned accesses answer with an error.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        resp_valid,
    output logic        busy,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_we;
    logic [AW+1:0]    r_addr;
    logic [31:0]      r_wdata;

    logic             w_mis;
    logic             w_fire;
    logic             w_arr_we;
    logic             w_arr_re;
    logic [31:0]      w_rdata;
    logic             w_unused_addr;

    // Upper address bits are dropped so accesses wrap on the array size.
    assign w_unused_addr = &{1'b0, Addr[31:AW+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && req_valid) begin
                r_we    <= MemWrite;
                r_addr  <= Addr[AW+1:0];
                r_wdata <= WriteData;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next     = WAIT;
                    w_cnt_next = CNT_LOAD;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_mis    = (r_addr[1:0] != 2'b00);
    // The edge that leaves the last WAIT cycle performs the array access.
    assign w_fire   = (r_state == WAIT) && (r_cnt == '0) && !reset;
    assign w_arr_we = w_fire && r_we && !w_mis;
    assign w_arr_re = w_fire && !r_we && !w_mis;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign busy         = (r_state == WAIT);
    assign resp_valid   = (r_state == RESP);
    assign misalign_err = resp_valid && w_mis;
    assign ReadData     = (resp_valid && !r_we && !w_mis) ? w_rdata : 32'd0;

endmodule
